// File: rtl/cache_ctrl.sv
// cache_ctrl: set-associative, write-through, no-write-allocate cache controller
// with true-LRU replacement. Each block holds one 24-bit word.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   cpu_req/we/addr/wdata CPU request; accepted when cpu_ready is high
//   cpu_ready            high only while idle
//   cpu_done             one-cycle completion pulse; cpu_hit/cpu_rdata valid with it
//   mem_req/we/addr/wdata backing-memory request, held until mem_ack
//   mem_rdata, mem_ack   memory read data and completion
//   hit_cnt, miss_cnt    wrapping counters of read hits and read misses
module cache_ctrl #(
  parameter int unsigned WAYS     = 4,
  parameter int unsigned NUM_SETS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [23:0] cpu_addr,
  input  logic [23:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic [23:0] cpu_rdata,
  output logic        cpu_hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [23:0] mem_wdata,
  input  logic [23:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int unsigned IdxW = $clog2(NUM_SETS);
  localparam int unsigned AgeW = $clog2(WAYS);
  localparam int unsigned TagW = 24 - 3 - IdxW;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMemRd,
    StMemWr,
    StFill,
    StResp
  } state_e;

  state_e r_state, w_state_next;

  // Latched request
  logic        r_we;
  logic [23:0] r_addr;
  logic [23:0] r_wdata;

  // Cache arrays
  logic [WAYS-1:0] r_valid [NUM_SETS];
  logic [TagW-1:0] r_tag   [NUM_SETS][WAYS];
  logic [23:0]     r_data  [NUM_SETS][WAYS];
  logic [AgeW-1:0] r_age   [NUM_SETS][WAYS];

  // Per-transaction results
  logic            r_hit;
  logic [AgeW-1:0] r_way;
  logic [23:0]     r_rdata;
  logic [15:0]     r_hit_cnt;
  logic [15:0]     r_miss_cnt;

  logic [IdxW-1:0] w_idx;
  logic [TagW-1:0] w_tag;
  logic            w_hit;
  logic [AgeW-1:0] w_hit_way;
  logic            w_found_inv;
  logic [AgeW-1:0] w_victim;
  logic            w_touch;
  logic [AgeW-1:0] w_touch_way;

  assign w_idx = r_addr[3 +: IdxW];
  assign w_tag = r_addr[23 -: TagW];

  // Tag compare across all ways of the indexed set
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!w_hit && r_valid[w_idx][i] && (r_tag[w_idx][i] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = AgeW'(i);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the least recently used one
  always_comb begin
    w_found_inv = 1'b0;
    w_victim    = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!w_found_inv && !r_valid[w_idx][i]) begin
        w_found_inv = 1'b1;
        w_victim    = AgeW'(i);
      end
    end
    if (!w_found_inv) begin
      for (int i = 0; i < WAYS; i++) begin
        if (r_age[w_idx][i] == AgeW'(WAYS - 1)) begin
          w_victim = AgeW'(i);
        end
      end
    end
  end

  // LRU promotion happens on any lookup hit and on every fill
  always_comb begin
    w_touch     = 1'b0;
    w_touch_way = '0;
    if (r_state == StLookup && w_hit) begin
      w_touch     = 1'b1;
      w_touch_way = w_hit_way;
    end else if (r_state == StFill) begin
      w_touch     = 1'b1;
      w_touch_way = r_way;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (cpu_req) w_state_next = StLookup;
      StLookup: begin
        if (r_we) begin
          w_state_next = StMemWr;
        end else if (w_hit) begin
          w_state_next = StResp;
        end else begin
          w_state_next = StMemRd;
        end
      end
      StMemRd:  if (mem_ack) w_state_next = StFill;
      StMemWr:  if (mem_ack) w_state_next = StResp;
      StFill:   w_state_next = StResp;
      StResp:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Datapath, arrays and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_hit      <= 1'b0;
      r_way      <= '0;
      r_rdata    <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        for (int i = 0; i < WAYS; i++) begin
          r_age[s][i] <= AgeW'(i);
        end
      end
    end else begin
      if (w_touch) begin
        for (int i = 0; i < WAYS; i++) begin
          if (r_age[w_idx][i] < r_age[w_idx][w_touch_way]) begin
            r_age[w_idx][i] <= r_age[w_idx][i] + AgeW'(1);
          end
        end
        r_age[w_idx][w_touch_way] <= '0;
      end

      case (r_state)
        StIdle: begin
          if (cpu_req) begin
            r_we    <= cpu_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
          end
        end
        StLookup: begin
          r_hit   <= w_hit;
          r_way   <= w_hit ? w_hit_way : w_victim;
          r_rdata <= '0;
          if (w_hit) begin
            if (r_we) begin
              r_data[w_idx][w_hit_way] <= r_wdata;
            end else begin
              r_rdata   <= r_data[w_idx][w_hit_way];
              r_hit_cnt <= r_hit_cnt + 16'd1;
            end
          end
        end
        StMemRd: begin
          if (mem_ack) begin
            r_rdata <= mem_rdata;
          end
        end
        StFill: begin
          r_valid[w_idx][r_way] <= 1'b1;
          r_tag[w_idx][r_way]   <= w_tag;
          r_data[w_idx][r_way]  <= r_rdata;
          r_miss_cnt            <= r_miss_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and registers only
  assign cpu_ready = (r_state == StIdle);
  assign cpu_done  = (r_state == StResp);
  assign cpu_hit   = cpu_done & r_hit;
  assign cpu_rdata = cpu_done ? r_rdata : '0;
  assign mem_req   = (r_state == StMemRd) || (r_state == StMemWr);
  assign mem_we    = (r_state == StMemWr);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed self-checking bench for cache_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [23:0] cpu_addr;
  logic [23:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_done;
  logic [23:0] cpu_rdata;
  logic        cpu_hit;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .cpu_hit   (cpu_hit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Results of the most recent transaction
  logic        x_done;
  logic        x_hit;
  logic [23:0] x_rdata;
  int          x_lat;
  int          x_mreq;
  logic        x_mwe;
  logic [23:0] x_maddr;
  logic [23:0] x_mwdata;

  // One CPU transaction; memory acks after 'delay' extra cycles of mem_req
  task automatic xact(input logic we, input logic [23:0] addr, input logic [23:0] wdata,
                      input logic [23:0] mdata, input int delay);
    int waited;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    @(negedge clk);
    cpu_req  = 1'b0;
    x_lat    = 1;
    x_done   = 1'b0;
    x_hit    = 1'bx;
    x_rdata  = 'x;
    x_mreq   = 0;
    x_mwe    = 1'b0;
    x_maddr  = '0;
    x_mwdata = '0;
    waited   = 0;
    for (int c = 0; c < 60 && !x_done; c++) begin
      if (cpu_done) begin
        x_done  = 1'b1;
        x_hit   = cpu_hit;
        x_rdata = cpu_rdata;
      end else begin
        if (mem_req) begin
          if (x_mreq == 0) begin
            x_mwe    = mem_we;
            x_maddr  = mem_addr;
            x_mwdata = mem_wdata;
          end
          x_mreq++;
          if (waited == delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mdata;
          end else begin
            waited++;
          end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        x_lat++;
      end
    end
  endtask

  logic done_seen;
  int   accepts;
  int   mreq_cnt;

  initial begin
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ready", cpu_ready, 1);
    chk("rst_done", cpu_done, 0);
    chk("rst_hit", cpu_hit, 0);
    chk("rst_memreq", {mem_req, mem_we}, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);
    chk("rst_cnts", {hit_cnt, miss_cnt}, 0);

    // Cold read miss, memory answers on the 4th mem_req cycle
    xact(1'b0, 24'h000040, 24'h0, 24'h00ABCD, 3);
    chk("miss1_done", x_done, 1);
    chk("miss1_hit", x_hit, 0);
    chk("miss1_rdata", x_rdata, 24'h00ABCD);
    chk("miss1_mreq", x_mreq, 4);
    chk("miss1_lat", x_lat, 7);
    chk("miss1_maddr", x_maddr, 24'h000040);
    chk("miss1_mwe", x_mwe, 0);
    chk("miss1_misscnt", miss_cnt, 1);

    // Same address now hits in 2 cycles with no memory traffic
    xact(1'b0, 24'h000040, 24'h0, 24'hFFFFFF, 0);
    chk("hit1_hit", x_hit, 1);
    chk("hit1_rdata", x_rdata, 24'h00ABCD);
    chk("hit1_lat", x_lat, 2);
    chk("hit1_mreq", x_mreq, 0);
    chk("hit1_hitcnt", hit_cnt, 1);

    // Five tags into set 0; tag 0 (oldest) is evicted by tag 4
    for (int t = 0; t < 5; t++) begin
      xact(1'b0, 24'(t << 7), 24'h0, 24'h000100 + 24'(t), 0);
      chk($sformatf("set0_t%0d_hit", t), x_hit, 0);
      chk($sformatf("set0_t%0d_rdata", t), x_rdata, 24'h000100 + 24'(t));
    end
    xact(1'b0, 24'h000000, 24'h0, 24'h000200, 1);
    chk("evict_t0_hit", x_hit, 0);
    chk("evict_t0_mreq", x_mreq, 2);
    chk("evict_t0_rdata", x_rdata, 24'h000200);
    // Tag 1 was the LRU victim of that refill; tag 2 must survive
    xact(1'b0, 24'h000100, 24'h0, 24'hFFFFFF, 0);
    chk("lru_t2_hit", x_hit, 1);
    chk("lru_t2_rdata", x_rdata, 24'h000102);
    chk("cnts_after_set0", {hit_cnt, miss_cnt}, {16'd2, 16'd7});

    // Write hit: write-through and cached word updated
    xact(1'b1, 24'h000040, 24'h123456, 24'h0, 1);
    chk("wr_hit_hit", x_hit, 1);
    chk("wr_hit_rdata", x_rdata, 0);
    chk("wr_hit_mreq", x_mreq, 2);
    chk("wr_hit_mwe", x_mwe, 1);
    chk("wr_hit_mwdata", x_mwdata, 24'h123456);
    chk("wr_hit_maddr", x_maddr, 24'h000040);
    chk("wr_cnts", {hit_cnt, miss_cnt}, {16'd2, 16'd7});
    xact(1'b0, 24'h000040, 24'h0, 24'hFFFFFF, 0);
    chk("rd_after_wr_hit", x_hit, 1);
    chk("rd_after_wr_rdata", x_rdata, 24'h123456);

    // Write miss does not allocate
    xact(1'b1, 24'h000C48, 24'h0000AA, 24'h0, 0);
    chk("wr_miss_hit", x_hit, 0);
    chk("wr_miss_mwe", x_mwe, 1);
    xact(1'b0, 24'h000C48, 24'h0, 24'h0000BB, 0);
    chk("rd_after_wrmiss_hit", x_hit, 0);
    chk("rd_after_wrmiss_rdata", x_rdata, 24'h0000BB);
    chk("cnts_before_abort", {hit_cnt, miss_cnt}, {16'd3, 16'd8});

    // Reset during MEM_RD, with a coincident mem_ack that must be ignored
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 24'h000800;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("abort_memreq_up", mem_req, 1);
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 24'h0BAD00;
    @(negedge clk);
    rst     = 1'b0;
    mem_ack = 1'b0;
    chk("abort_memreq_drop", mem_req, 0);
    done_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (cpu_done || mem_req) done_seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_cnts", {hit_cnt, miss_cnt}, 0);
    xact(1'b0, 24'h000800, 24'h0, 24'h000777, 0);
    chk("post_abort_hit", x_hit, 0);
    chk("post_abort_rdata", x_rdata, 24'h000777);
    chk("post_abort_cnts", {hit_cnt, miss_cnt}, {16'd0, 16'd1});

    // Stray mem_ack while idle
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack_ready", cpu_ready, 1);
    chk("stray_ack_memreq", {mem_req, cpu_done}, 0);

    // cpu_req held high across a whole miss: accepted exactly once
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 24'h000880;
    accepts   = 0;
    mreq_cnt  = 0;
    done_seen = 1'b0;
    x_hit     = 1'bx;
    x_rdata   = 'x;
    for (int c = 0; c < 30 && !done_seen; c++) begin
      if (cpu_done) begin
        done_seen = 1'b1;
        x_hit     = cpu_hit;
        x_rdata   = cpu_rdata;
      end else begin
        if (cpu_ready) accepts++;
        if (mem_req) begin
          mreq_cnt++;
          if (mreq_cnt == 3) begin
            mem_ack   = 1'b1;
            mem_rdata = 24'h000321;
          end
        end
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end
    cpu_req = 1'b0;
    chk("held_req_done", done_seen, 1);
    chk("held_req_accepts", accepts, 1);
    chk("held_req_mreq", mreq_cnt, 3);
    chk("held_req_hit", x_hit, 0);
    chk("held_req_rdata", x_rdata, 24'h000321);
    chk("held_req_misscnt", miss_cnt, 2);
    @(negedge clk);
    chk("held_req_idle", {cpu_ready, mem_req, cpu_done}, 3'b100);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
